// File: rtl/uart_rx_ovs.sv
// 16x-oversampled UART receiver with 3-sample mid-bit majority vote,
// optional parity, and per-frame parity/framing/break status.
module uart_rx_ovs #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       P_EN      = (PARITY_EN != 0);
  localparam logic       P_ODD     = (PARITY_ODD != 0);

  logic       rx_meta;
  logic       rx_s;
  logic [2:0] state;
  logic [4:0] s_cnt;
  logic [2:0] n_cnt;
  logic [7:0] sh;
  logic [7:0] sh_shifted;
  logic       smp7;
  logic       smp8;
  logic       par_bit;
  logic       stop_bit;
  logic       vote;
  logic       fe_next;

  // Third sample is the live rx_s on the s==9 tick.
  assign vote    = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
  assign fe_next = ~stop_bit;
  assign state_dbg = state;

  always_comb begin
    sh_shifted = {1'b0, sh[7:1]};
    sh_shifted[DBIT-1] = vote;
  end

  // rx_done_tick is a bare one-cycle strobe with no back-pressure:
  // dout and the flags are valid on it and hold until the next strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= ST_IDLE;
      s_cnt        <= 5'd0;
      n_cnt        <= 3'd0;
      sh           <= 8'd0;
      smp7         <= 1'b0;
      smp8         <= 1'b0;
      par_bit      <= 1'b0;
      stop_bit     <= 1'b0;
      dout         <= 8'd0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      rx_done_tick <= 1'b0;

      if (state == ST_IDLE) begin
        if (!rx_s) begin
          state <= ST_START;
          s_cnt <= 5'd0;
        end
      end else if (s_tick) begin
        s_cnt <= s_cnt + 5'd1;
        if (s_cnt == 5'd7) smp7 <= rx_s;
        if (s_cnt == 5'd8) smp8 <= rx_s;

        if (s_cnt == 5'd9) begin
          case (state)
            ST_START:  if (vote) state <= ST_IDLE;
            ST_DATA:   sh <= sh_shifted;
            ST_PARITY: par_bit <= vote;
            ST_STOP:   stop_bit <= vote;
            default:   state <= ST_IDLE;
          endcase
        end

        if (state != ST_STOP && s_cnt == 5'd15) begin
          s_cnt <= 5'd0;
          case (state)
            ST_START: begin
              state <= ST_DATA;
              n_cnt <= 3'd0;
            end
            ST_DATA: begin
              if (n_cnt == N_LAST) state <= P_EN ? ST_PARITY : ST_STOP;
              else                 n_cnt <= n_cnt + 3'd1;
            end
            ST_PARITY: state <= ST_STOP;
            default:   state <= ST_IDLE;
          endcase
        end

        if (state == ST_STOP && s_cnt == STOP_LAST) begin
          state        <= ST_IDLE;
          rx_done_tick <= 1'b1;
          dout         <= sh;
          parity_err   <= P_EN & (^sh ^ par_bit ^ P_ODD);
          frame_err    <= fe_next;
          break_det    <= fe_next & (sh == 8'd0) & ~(P_EN & par_bit);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8N1, 8E1 and 7N1 instances, each on its own rx line.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam logic [2:0] ST_IDLE = 3'd0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s_tick = 1'b0;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_7 = 1'b1;

  logic [7:0] dout_a, dout_p, dout_7;
  logic done_a, done_p, done_7;
  logic pe_a, pe_p, pe_7;
  logic fe_a, fe_p, fe_7;
  logic bd_a, bd_p, bd_7;
  logic [2:0] st_a, st_p, st_7;

  int total = 0;
  int bad = 0;
  int done_cnt_a = 0;
  int cnt_before;

  uart_rx_ovs u_a (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a), .parity_err(pe_a),
    .frame_err(fe_a), .break_det(bd_a), .state_dbg(st_a)
  );

  uart_rx_ovs #(.PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_p),
    .dout(dout_p), .rx_done_tick(done_p), .parity_err(pe_p),
    .frame_err(fe_p), .break_det(bd_p), .state_dbg(st_p)
  );

  uart_rx_ovs #(.DBIT(7)) u_7 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_7),
    .dout(dout_7), .rx_done_tick(done_7), .parity_err(pe_7),
    .frame_err(fe_7), .break_det(bd_7), .state_dbg(st_7)
  );

  // clock / tick / reset
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) if (done_a) done_cnt_a++;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!s_tick);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_p = v;
      default: rx_7 = v;
    endcase
  endtask

  task automatic idle_ticks(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) wait_tick();
  endtask

  // Value set before the t-th wait of a bit is seen by the DUT at s==t.
  task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                            input logic par_en, input logic par, input logic stop_v,
                            input logic noise);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(par);
    bits.push_back(stop_v);
    wait_tick();
    foreach (bits[i]) begin
      for (int t = 0; t < 16; t++) begin
        set_line(sel, (noise && t == 8) ? ~bits[i] : bits[i]);
        wait_tick();
      end
    end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_dout", dout_a, 8'h00);
    check_val("rst_done", done_a, 1'b0);
    check_val("rst_flags", {pe_a, fe_a, bd_a}, 3'b000);
    check_val("rst_state", st_a, ST_IDLE);
    reset_n = 1'b1;
    idle_ticks(0, 4);

    // 8N1 0xA5: done pulse lands on the s==15 tick of the stop bit
    send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("a5_done", done_a, 1'b1);
    check_val("a5_dout", dout_a, 8'hA5);
    check_val("a5_flags", {pe_a, fe_a, bd_a}, 3'b000);
    @(posedge clk); #1;
    check_val("a5_pulse_width", done_a, 1'b0);
    idle_ticks(0, 8);
    check_val("a5_count", done_cnt_a, 1);

    // start glitch
    set_line(0, 1'b0);
    repeat (4) wait_tick();
    idle_ticks(0, 16);
    check_val("glitch_state", st_a, ST_IDLE);
    check_val("glitch_count", done_cnt_a, 1);
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("3c_done", done_a, 1'b1);
    check_val("3c_dout", dout_a, 8'h3C);
    idle_ticks(0, 8);

    // s==8 sample inverted on every bit
    send_frame(0, 8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("noise_done", done_a, 1'b1);
    check_val("noise_dout", dout_a, 8'h0F);
    check_val("noise_flags", {pe_a, fe_a, bd_a}, 3'b000);
    idle_ticks(0, 8);

    // line held low 12 bit times; break frame ends after 10 bits
    cnt_before = done_cnt_a;
    wait_tick();
    set_line(0, 1'b0);
    repeat (192) wait_tick();
    check_val("brk_count", done_cnt_a, cnt_before + 1);
    check_val("brk_dout", dout_a, 8'h00);
    check_val("brk_fe", fe_a, 1'b1);
    check_val("brk_bd", bd_a, 1'b1);
    check_val("brk_pe", pe_a, 1'b0);
    // restart right after the break frame sees 2 low bits then high: 0xFE
    idle_ticks(0, 160);
    check_val("brk2_count", done_cnt_a, cnt_before + 2);
    check_val("brk2_dout", dout_a, 8'hFE);
    check_val("brk2_flags", {fe_a, bd_a}, 2'b00);
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("55_done", done_a, 1'b1);
    check_val("55_dout", dout_a, 8'h55);
    check_val("55_flags", {pe_a, fe_a, bd_a}, 3'b000);
    idle_ticks(0, 8);

    // reset mid data bit 3 (0x55 pattern on the line)
    cnt_before = done_cnt_a;
    wait_tick();
    for (int i = 0; i < 72; i++) begin
      set_line(0, (i < 16) ? 1'b0 : ((i < 32) ? 1'b1 : ((i < 48) ? 1'b0 : ((i < 64) ? 1'b1 : 1'b0))));
      wait_tick();
    end
    #2;
    reset_n = 1'b0;
    rx_a = 1'b1;
    #1;
    check_val("mid_rst_dout", dout_a, 8'h00);
    check_val("mid_rst_state", st_a, ST_IDLE);
    check_val("mid_rst_done", done_a, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_ticks(0, 200);
    check_val("mid_rst_count", done_cnt_a, cnt_before);
    send_frame(0, 8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("81_done", done_a, 1'b1);
    check_val("81_dout", dout_a, 8'h81);
    idle_ticks(0, 4);

    // even parity
    send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("par_ok_done", done_p, 1'b1);
    check_val("par_ok_dout", dout_p, 8'h07);
    check_val("par_ok_flags", {pe_p, fe_p, bd_p}, 3'b000);
    idle_ticks(1, 4);
    send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("par_bad_done", done_p, 1'b1);
    check_val("par_bad_dout", dout_p, 8'h07);
    check_val("par_bad_flags", {pe_p, fe_p, bd_p}, 3'b100);
    idle_ticks(1, 4);

    // 7-bit data
    send_frame(2, 8'h7F, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("d7_done", done_7, 1'b1);
    check_val("d7_dout", dout_7, 8'h7F);
    check_val("d7_msb", dout_7[7], 1'b0);
    check_val("d7_flags", {pe_7, fe_7, bd_7}, 3'b000);
    idle_ticks(2, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
